sram_controller: RTL

Multi-cycle controller between the MEM stage and an external 16-bit asynchronous SRAM that backs data memory. It splits each 32-bit load or store into two half-word SRAM accesses, each held for a programmable number of wait cycles. While an access is in flight it deasserts `o_Ready`; the top level uses `~o_Ready` to freeze every pipeline stage and stage register. One controller serves the single data-memory port; the instruction path is unaffected.

---
 rtl/sram_controller_if.sv | 46 ++++
 rtl/sram_controller.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sram_controller_if.sv
// MEM-stage request/response and SRAM pin bundle for sram_controller.
// The slave modport is the controller; the master modport is the MEM stage and SRAM side.
interface sram_controller_if;
  logic        i_Sig_Memory_Read_Enable;
  logic        i_Sig_Memory_Write_Enable;
  logic [31:0] i_Address;
  logic [31:0] i_Write_Data;
  logic [31:0] o_Read_Data;
  logic        o_Ready;
  logic        o_Error;
  logic [17:0] o_SRAM_Address;
  logic [15:0] o_SRAM_Write_Data;
  logic        o_SRAM_Data_Drive;
  logic        o_SRAM_WE_N;
  logic [15:0] i_SRAM_Read_Data;

  modport slave (
    input  i_Sig_Memory_Read_Enable,
    input  i_Sig_Memory_Write_Enable,
    input  i_Address,
    input  i_Write_Data,
    output o_Read_Data,
    output o_Ready,
    output o_Error,
    output o_SRAM_Address,
    output o_SRAM_Write_Data,
    output o_SRAM_Data_Drive,
    output o_SRAM_WE_N,
    input  i_SRAM_Read_Data
  );

  modport master (
    output i_Sig_Memory_Read_Enable,
    output i_Sig_Memory_Write_Enable,
    output i_Address,
    output i_Write_Data,
    input  o_Read_Data,
    input  o_Ready,
    input  o_Error,
    input  o_SRAM_Address,
    input  o_SRAM_Write_Data,
    input  o_SRAM_Data_Drive,
    input  o_SRAM_WE_N,
    output i_SRAM_Read_Data
  );
endinterface

// File: rtl/sram_controller.sv
// Splits 32-bit data-memory loads/stores into two held half-word accesses on a 16-bit async SRAM.
// Optional feature macro: SRAM_RANGE_CHECK_EN (out-of-window requests skip the SRAM and pulse o_Error).
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned ADDR_BASE   = 1024
) (
  input  logic               clk,
  input  logic               reset,
  sram_controller_if.slave   bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WORD_W = 17;
  localparam int unsigned ADDR_W = 18;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic [CNT_W-1:0]    r_cnt,        w_cnt_nxt;
  logic [DATA_W-1:0]   r_read_data,  w_read_data_nxt;
  logic [ADDR_W-1:0]   r_sram_addr,  w_sram_addr_nxt;
  logic [HALF_W-1:0]   r_sram_wdata, w_sram_wdata_nxt;
  logic                r_sram_drive, w_sram_drive_nxt;
  logic                r_sram_we_n,  w_sram_we_n_nxt;

  logic                w_req;
  logic                w_is_write;
  logic                w_is_read;
  logic                w_last;
  logic                w_ready;
  logic                w_out_of_range;
  logic [WORD_W-1:0]   w_word;

  assign w_req      = bus.i_Sig_Memory_Read_Enable | bus.i_Sig_Memory_Write_Enable;
  assign w_is_write = bus.i_Sig_Memory_Write_Enable;
  assign w_is_read  = bus.i_Sig_Memory_Read_Enable & ~bus.i_Sig_Memory_Write_Enable;
  assign w_last     = (r_cnt == CNT_LAST);
  assign w_word     = WORD_W'((bus.i_Address - ADDR_BASE) >> 2);

`ifdef SRAM_RANGE_CHECK_EN
  logic r_error;
  logic w_error_nxt;

  // Window is [ADDR_BASE, ADDR_BASE + 512 KiB); compared in 33 bits so the top bound cannot wrap.
  assign w_out_of_range = (bus.i_Address < ADDR_BASE) ||
                          ({1'b0, bus.i_Address} >= (33'(ADDR_BASE) + 33'(1 << 19)));
  assign w_error_nxt    = (r_state == S_IDLE) && w_req && w_out_of_range;

  always_ff @(posedge clk) begin
    if (reset) r_error <= 1'b0;
    else       r_error <= w_error_nxt;
  end

  assign bus.o_Error = r_error;
`else
  assign w_out_of_range = 1'b0;
  assign bus.o_Error    = 1'b0;
`endif

  // Next-state, counter, read capture, and SRAM pin values for the coming cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_read_data_nxt  = r_read_data;
    w_ready          = 1'b0;
    w_sram_we_n_nxt  = 1'b1;
    w_sram_drive_nxt = 1'b0;
    w_sram_wdata_nxt = '0;
    w_sram_addr_nxt  = '0;

    unique case (r_state)
      S_IDLE: begin
        w_ready   = ~w_req;
        w_cnt_nxt = '0;
        if (w_req) begin
          if (w_out_of_range) begin
            w_state_nxt = S_DONE;
            if (w_is_read) w_read_data_nxt = '0;
          end else begin
            w_state_nxt = S_LOW;
          end
        end
      end
      S_LOW: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_HIGH;
          if (w_is_read) w_read_data_nxt[15:0] = bus.i_SRAM_Read_Data;
        end
      end
      S_HIGH: begin
        w_cnt_nxt = r_cnt + 4'd1;
        if (w_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
          if (w_is_read) w_read_data_nxt[31:16] = bus.i_SRAM_Read_Data;
        end
      end
      S_DONE: begin
        w_ready     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Pins are registered, so they are derived from the state being entered.
    if ((w_state_nxt == S_LOW) || (w_state_nxt == S_HIGH)) begin
      w_sram_addr_nxt = {w_word, (w_state_nxt == S_HIGH)};
      if (w_is_write) begin
        w_sram_we_n_nxt  = 1'b0;
        w_sram_drive_nxt = 1'b1;
        w_sram_wdata_nxt = (w_state_nxt == S_HIGH) ? bus.i_Write_Data[31:16]
                                                   : bus.i_Write_Data[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_read_data  <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_sram_drive <= 1'b0;
      r_sram_we_n  <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_read_data  <= w_read_data_nxt;
      r_sram_addr  <= w_sram_addr_nxt;
      r_sram_wdata <= w_sram_wdata_nxt;
      r_sram_drive <= w_sram_drive_nxt;
      r_sram_we_n  <= w_sram_we_n_nxt;
    end
  end

  assign bus.o_Ready           = w_ready;
  assign bus.o_Read_Data       = r_read_data;
  assign bus.o_SRAM_Address    = r_sram_addr;
  assign bus.o_SRAM_Write_Data = r_sram_wdata;
  assign bus.o_SRAM_Data_Drive = r_sram_drive;
  assign bus.o_SRAM_WE_N       = r_sram_we_n;

endmodule
